// File: rtl/ctrl_pc_seq.sv
// ctrl_pc_seq -- program-counter sequencer with a circular return-address stack.
//
// Each unstalled cycle the PC either increments, jumps to a branch target,
// calls (pushes the return address and jumps) or returns (pops the return
// address into the PC). When a push finds the stack full, it overwrites the
// oldest entry. Misuse of the stack is recorded in sticky flags that only
// reset clears.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   stall_i        in   hold all state; control inputs this cycle are dropped
//   branch_taken_i in   redirect PC to branch_tgt_i
//   call_i         in   push PC+1, redirect to branch_tgt_i
//   ret_i          in   pop return address into PC
//   branch_tgt_i   in   [PC_WID] branch / call target
//   prog_ctr       out  [PC_WID] current program counter (registered)
//   ras_cnt        out  valid stack entries, saturates at RAS_DEPTH
//   ras_ovf        out  sticky: push while stack full
//   ras_unf        out  sticky: pop while stack empty
//   seq_err        out  sticky: call_i and ret_i in the same cycle
module ctrl_pc_seq #(
  parameter int PC_WID    = 10,
  parameter int RESET_VEC = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall_i,
  input  logic                             branch_taken_i,
  input  logic                             call_i,
  input  logic                             ret_i,
  input  logic [PC_WID-1:0]                branch_tgt_i,
  output logic [PC_WID-1:0]                prog_ctr,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_cnt,
  output logic                             ras_ovf,
  output logic                             ras_unf,
  output logic                             seq_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

  logic [PC_WID-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              err_q, err_d;
  logic [PC_WID-1:0] stack_q [RAS_DEPTH];
  logic [PC_WID-1:0] stack_d [RAS_DEPTH];

  logic [PC_WID-1:0] pc_inc;
  logic [PTR_W-1:0]  top_inc;
  logic [PTR_W-1:0]  top_dec;

  assign pc_inc = pc_q + PC_WID'(1);

  // Explicit wrap so non-power-of-two depths stay inside the buffer.
  assign top_inc = (top_q == PTR_LAST) ? '0 : top_q + PTR_W'(1);
  assign top_dec = (top_q == '0) ? PTR_LAST : top_q - PTR_W'(1);

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    err_d   = err_q;
    stack_d = stack_q;

    if (stall_i) begin
      // Hold everything; any control request this cycle is lost.
    end else if (call_i && ret_i) begin
      err_d = 1'b1;
      pc_d  = pc_inc;
    end else if (ret_i) begin
      if (cnt_q != '0) begin
        pc_d  = stack_q[top_q];
        top_d = top_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        unf_d = 1'b1;
        pc_d  = pc_inc;
      end
    end else if (call_i) begin
      // When full, top+1 is the oldest entry, so the push overwrites it.
      stack_d[top_inc] = pc_inc;
      top_d            = top_inc;
      pc_d             = branch_tgt_i;
      if (cnt_q == CNT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (branch_taken_i) begin
      pc_d = branch_tgt_i;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_WID'(RESET_VEC);
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
    end
  end

  // Stack contents carry no meaning after reset (ras_cnt is 0), so the
  // storage itself is not reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stack_q <= stack_d;
    end
  end

  assign prog_ctr = pc_q;
  assign ras_cnt  = cnt_q;
  assign ras_ovf  = ovf_q;
  assign ras_unf  = unf_q;
  assign seq_err  = err_q;

endmodule

// File: tb/tb_ctrl_pc_seq.sv
// tb_ctrl_pc_seq -- scoreboard bench for ctrl_pc_seq (default parameters).
// Each driven cycle steps a behavioural model (a queue-based stack that
// drops its oldest entry when full), pushes the expected outputs, and pops
// and compares them one edge later.
module tb_ctrl_pc_seq;

  localparam int PC_WID = 10;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall_i;
  logic              branch_taken_i;
  logic              call_i;
  logic              ret_i;
  logic [PC_WID-1:0] branch_tgt_i;
  logic [PC_WID-1:0] prog_ctr;
  logic [2:0]        ras_cnt;
  logic              ras_ovf;
  logic              ras_unf;
  logic              seq_err;

  ctrl_pc_seq #(.PC_WID(PC_WID), .RESET_VEC(1), .RAS_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .call_i         (call_i),
    .ret_i          (ret_i),
    .branch_tgt_i   (branch_tgt_i),
    .prog_ctr       (prog_ctr),
    .ras_cnt        (ras_cnt),
    .ras_ovf        (ras_ovf),
    .ras_unf        (ras_unf),
    .seq_err        (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_WID-1:0] pc;
    int                cnt;
    logic              ovf;
    logic              unf;
    logic              err;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [PC_WID-1:0] m_pc;
  logic [PC_WID-1:0] m_stack[$];
  logic              m_ovf, m_unf, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic br,
                            input logic ca, input logic re, input logic [PC_WID-1:0] tgt);
    if (rst) begin
      m_pc = 1;
      m_stack.delete();
      m_ovf = 0; m_unf = 0; m_err = 0;
    end else if (st) begin
    end else if (ca && re) begin
      m_err = 1;
      m_pc  = m_pc + 1'b1;
    end else if (re) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_unf = 1;
        m_pc  = m_pc + 1'b1;
      end
    end else if (ca) begin
      if (m_stack.size() == DEPTH) begin
        void'(m_stack.pop_front());
        m_ovf = 1;
      end
      m_stack.push_back(m_pc + 1'b1);
      m_pc = tgt;
    end else if (br) begin
      m_pc = tgt;
    end else begin
      m_pc = m_pc + 1'b1;
    end
  endtask

  // One transaction: drive, predict, clock, then compare against the scoreboard.
  task automatic cycle(input string name, input logic rst, input logic st, input logic br,
                       input logic ca, input logic re, input logic [PC_WID-1:0] tgt);
    exp_t e;
    exp_t got;
    reset = rst; stall_i = st; branch_taken_i = br; call_i = ca; ret_i = re; branch_tgt_i = tgt;
    model_step(rst, st, br, ca, re, tgt);
    e.pc = m_pc; e.cnt = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf; e.err = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({name, ".pc"},  32'(prog_ctr), 32'(got.pc));
      check({name, ".cnt"}, 32'(ras_cnt),  32'(got.cnt));
      check({name, ".ovf"}, 32'(ras_ovf),  32'(got.ovf));
      check({name, ".unf"}, 32'(ras_unf),  32'(got.unf));
      check({name, ".err"}, 32'(seq_err),  32'(got.err));
    end
    $display("txn %-10s rst=%0b st=%0b br=%0b call=%0b ret=%0b tgt=0x%03h -> pc=0x%03h cnt=%0d ovf=%0b unf=%0b err=%0b",
             name, rst, st, br, ca, re, tgt, prog_ctr, ras_cnt, ras_ovf, ras_unf, seq_err);
  endtask

  logic [PC_WID-1:0] pc_before;

  initial begin
    reset = 1; stall_i = 0; branch_taken_i = 0; call_i = 0; ret_i = 0; branch_tgt_i = '0;
    m_pc = '0; m_ovf = 0; m_unf = 0; m_err = 0;

    // Reset and idle count-up
    cycle("reset", 1, 0, 0, 0, 0, 0);
    cycle("reset", 1, 0, 0, 0, 0, 0);
    check("rst_pc", 32'(prog_ctr), 32'd1);
    for (int i = 0; i < 3; i++) cycle("idle", 0, 0, 0, 0, 0, 0);
    check("idle_pc", 32'(prog_ctr), 32'd4);

    // PC wrap at all-ones
    cycle("br3ff", 0, 0, 1, 0, 0, 10'h3FF);
    cycle("wrap", 0, 0, 0, 0, 0, 0);
    check("wrap_pc", 32'(prog_ctr), 32'd0);

    // Single call / return
    cycle("br5", 0, 0, 1, 0, 0, 10'd5);
    cycle("call40", 0, 0, 1, 1, 0, 10'h40);
    check("call_cnt", 32'(ras_cnt), 32'd1);
    cycle("idle", 0, 0, 0, 0, 0, 0);
    cycle("idle", 0, 0, 0, 0, 0, 0);
    cycle("ret", 0, 0, 1, 0, 1, 10'h3AA);
    check("ret_pc", 32'(prog_ctr), 32'd6);

    // Overflow then underflow
    for (int i = 0; i < 5; i++) cycle("call1xx", 0, 0, 0, 1, 0, 10'(10'h100 + i));
    check("ovf_flag", 32'(ras_ovf), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle("ret", 0, 0, 0, 0, 1, 0);
      check("ret_addr", 32'(prog_ctr), 32'(10'h104 - i));
    end
    cycle("ret_unf", 0, 0, 0, 0, 1, 0);
    check("unf_pc", 32'(prog_ctr), 32'h102);

    // Stall drops control requests
    cycle("call20", 0, 0, 0, 1, 0, 10'h20);
    pc_before = prog_ctr;
    cycle("stall", 0, 1, 1, 0, 0, 10'h55);
    cycle("stall", 0, 1, 0, 1, 0, 10'h66);
    cycle("stall", 0, 1, 1, 0, 1, 10'h77);
    check("stall_pc", 32'(prog_ctr), 32'(pc_before));
    cycle("release", 0, 0, 0, 0, 0, 0);
    check("rel_pc", 32'(prog_ctr), 32'(pc_before + 1'b1));

    // Illegal call+ret, then reset during stall and mid-call
    cycle("br10", 0, 0, 1, 0, 0, 10'h10);
    cycle("callret", 0, 0, 1, 1, 1, 10'h200);
    check("seq_pc", 32'(prog_ctr), 32'h11);
    check("seq_err", 32'(seq_err), 32'd1);
    cycle("rst_stall", 1, 1, 1, 1, 0, 10'h300);
    check("rst2_pc", 32'(prog_ctr), 32'd1);
    cycle("idle", 0, 0, 0, 0, 0, 0);
    check("post_rst", 32'(prog_ctr), 32'd2);
    cycle("call33", 0, 0, 0, 1, 0, 10'h33);
    cycle("rst_call", 1, 0, 0, 1, 0, 10'h44);
    cycle("ret_empty", 0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_pc_seq.md
CTRL_PC_SEQ -- requirements
Module: ctrl_pc_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- PC_WID, 10, program-counter width in bits.
- RESET_VEC, 1, program-counter value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries; legal range 2..16.
REQ-002 The block SHALL have these ports (name direction width meaning):
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_i  input  1  freezes all state when high.
- branch_taken_i  input  1  redirect PC to branch_tgt_i.
- call_i  input  1  push return address, then redirect to branch_tgt_i.
- ret_i  input  1  pop return address into PC.
- branch_tgt_i  input  PC_WID  target for branch or call.
- prog_ctr  output  PC_WID  current program counter, registered.
- ras_cnt  output  $clog2(RAS_DEPTH+1)  valid stack entries, registered.
- ras_ovf  output  1  sticky: push attempted with stack full.
- ras_unf  output  1  sticky: pop attempted with stack empty.
- seq_err  output  1  sticky: call_i and ret_i asserted in the same cycle.

Function
REQ-003 Every output SHALL be registered; inputs sampled at edge N SHALL be reflected on the outputs after edge N (one-cycle latency).
REQ-004 Per edge, action priority SHALL be: reset > stall_i > illegal (call_i & ret_i) > ret_i > call_i > branch_taken_i > increment.
REQ-005 stall_i high: prog_ctr, stack contents, ras_cnt and all flags SHALL hold; branch, call and ret SHALL be dropped, not deferred.
REQ-006 Increment: prog_ctr <= prog_ctr + 1, modulo 2^PC_WID (all-ones wraps to 0, no flag).
REQ-007 branch_taken_i alone: prog_ctr <= branch_tgt_i; stack unchanged.
REQ-008 call_i: push (prog_ctr + 1) mod 2^PC_WID; prog_ctr <= branch_tgt_i; ras_cnt increments, saturating at RAS_DEPTH. branch_taken_i is ignored.
REQ-009 Push with ras_cnt == RAS_DEPTH: the oldest entry SHALL be overwritten (circular); ras_cnt stays RAS_DEPTH; ras_ovf <= 1.
REQ-010 ret_i with ras_cnt > 0: prog_ctr <= most recently pushed entry; ras_cnt decrements. branch_taken_i is ignored.
REQ-011 ret_i with ras_cnt == 0: ras_unf <= 1; prog_ctr increments; stack pointer and contents unchanged.
REQ-012 call_i & ret_i in the same cycle: seq_err <= 1; prog_ctr increments; stack unchanged; branch_taken_i is ignored.
REQ-013 The stack SHALL be a circular buffer of RAS_DEPTH x PC_WID registers with a top pointer; push writes top+1 mod RAS_DEPTH, pop reads top and moves the pointer to top-1 mod RAS_DEPTH.
REQ-014 Sticky flags SHALL clear only on reset.

Reset
REQ-015 reset high at an edge: prog_ctr <= RESET_VEC[PC_WID-1:0]; ras_cnt <= 0; top pointer <= 0; ras_ovf, ras_unf and seq_err <= 0. Stack contents are don't-care.
REQ-016 Reset SHALL override stall_i and all control inputs, including mid-call or mid-return sequences.
REQ-017 After reset deasserts, the first non-stalled edge SHALL increment prog_ctr from RESET_VEC.

Verification
REQ-018 The bench SHALL cover the following scenarios (PC_WID=10, RESET_VEC=1, RAS_DEPTH=4 unless noted):
- Reset, then 3 idle cycles: prog_ctr = 1, 2, 3, 4; ras_cnt = 0; all flags 0.
- prog_ctr = 0x3FF, idle: next prog_ctr = 0x000, no flag.
- At prog_ctr = 5: call_i with tgt 0x40, then 2 idle cycles, then ret_i: prog_ctr = 0x40, 0x41, 0x42, 6; ras_cnt = 1 then 0.
- 5 consecutive calls (tgt 0x100..0x104), then 5 rets: first 4 rets return the addresses of calls 5..2; ras_ovf = 1 after the 5th call; 5th ret sets ras_unf = 1 and increments prog_ctr.
- stall_i held 3 cycles while branch_taken_i, call_i and ret_i toggle: prog_ctr and ras_cnt constant; the branch is lost after release.
- call_i & ret_i together at prog_ctr = 0x10: seq_err = 1, prog_ctr = 0x11, ras_cnt unchanged; then reset during stall: prog_ctr = 1 and all flags 0.
